intersection_scheduler: RTL and testbench

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

---
 rtl/intersection_scheduler.sv | 140 ++++++++++++++
 tb/tb_intersection_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// Intersection scheduler: picks the densest requesting lane (round-robin on ties), grants it, then enforces all-red clearance.
// Optional starvation guard is compiled in when SCHED_STARVE_GUARD_EN is defined.
module intersection_scheduler #(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned ALL_RED_TIME = 10,
  parameter int unsigned MAX_SKIP     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_LANES-1:0]   lane_req,
  input  logic [NUM_LANES-1:0]   lane_red,
  input  logic [2*NUM_LANES-1:0] density,
  output logic [NUM_LANES-1:0]   grant,
  output logic [IDX_W-1:0]       active_lane,
  output logic                   busy,
  output logic                   all_red
);

  localparam int unsigned CNT_W = (ALL_RED_TIME > 1) ? $clog2(ALL_RED_TIME) : 1;

  if (NUM_LANES > (1 << IDX_W) || ALL_RED_TIME == 0 || MAX_SKIP == 0) begin : g_bad_cfg
    $error("intersection_scheduler: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    WAIT_GO  = 3'd2,
    WAIT_RED = 3'd3,
    ALL_RED  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  last, last_n;
  logic [IDX_W-1:0]  active_n;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [2:0]        best;
  logic [2:0]        key [NUM_LANES];
  logic [NUM_LANES-1:0] starved;
  int unsigned       rr_idx;

`ifdef SCHED_STARVE_GUARD_EN
  localparam int unsigned SKIP_W = $clog2(MAX_SKIP + 1);
  logic [SKIP_W-1:0] skip [NUM_LANES];

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) starved[i] = (skip[i] >= SKIP_W'(MAX_SKIP));
  end

  // Skip counters saturate at MAX_SKIP; only arbitrations actually performed in IDLE count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) skip[i] <= '0;
    end else if (state == IDLE && sel_found) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (IDX_W'(i) == sel_idx) skip[i] <= '0;
        else if (lane_req[i] && skip[i] < SKIP_W'(MAX_SKIP)) skip[i] <= skip[i] + 1'b1;
      end
    end
  end
`else
  assign starved = '0;
`endif

  // Priority key: starvation bit dominates density.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) key[i] = {starved[i], density[2*i +: 2]};
  end

  // Scan from last+1 so the first strict maximum found is the round-robin tie winner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best      = '0;
    rr_idx    = 0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      rr_idx = 32'(last) + 32'd1 + k;
      if (rr_idx >= NUM_LANES) rr_idx = rr_idx - NUM_LANES;
      if (lane_req[IDX_W'(rr_idx)] && (!sel_found || key[IDX_W'(rr_idx)] > best)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(rr_idx);
        best      = key[IDX_W'(rr_idx)];
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    active_n = active_lane;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_n  = GRANT;
          active_n = sel_idx;
          last_n   = sel_idx;
        end
      end
      GRANT:    state_n = WAIT_GO;
      WAIT_GO:  if (!lane_red[active_lane]) state_n = WAIT_RED;
      WAIT_RED: begin
        if (lane_red[active_lane]) begin
          state_n = ALL_RED;
          cnt_n   = CNT_W'(ALL_RED_TIME - 1);
        end
      end
      ALL_RED: begin
        if (cnt == '0) state_n = IDLE;
        else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= IDX_W'(NUM_LANES - 1);
      grant       <= '0;
      active_lane <= '0;
      busy        <= 1'b0;
      all_red     <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      active_lane <= active_n;
      grant       <= (state_n == GRANT) ? (NUM_LANES'(1) << active_n) : '0;
      busy        <= (state_n != IDLE);
      all_red     <= (state_n == IDLE) || (state_n == ALL_RED);
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: stimulus queues expected grants, a monitor checks each grant pulse.
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] lane_req;
  logic [3:0] lane_red;
  logic [7:0] density;
  logic [3:0] grant;
  logic [1:0] active_lane;
  logic       busy;
  logic       all_red;

  int n_cmp = 0;
  int n_err = 0;
  int grant_cnt = 0;
  int exp_q[$];

  intersection_scheduler dut (
    .clk(clk), .reset(reset), .lane_req(lane_req), .lane_red(lane_red),
    .density(density), .grant(grant), .active_lane(active_lane),
    .busy(busy), .all_red(all_red)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    lane_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_grants(input int target);
    int t = 0;
    while (grant_cnt < target && t < 300) begin
      step();
      t++;
    end
    check("grant_wait", int'(grant_cnt >= target), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      step();
      t++;
    end
    check("idle_wait", int'(busy), 0);
  endtask

  // Lane controller model: drops red one cycle after its grant, restores it five cycles later.
  initial begin
    int l;
    lane_red = '1;
    forever begin
      @(negedge clk);
      if (!reset && grant != '0) begin
        l = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) l = i;
        @(negedge clk);
        lane_red[l] = 1'b0;
        repeat (5) @(negedge clk);
        lane_red[l] = 1'b1;
      end
    end
  end

  // Monitor: every grant pulse must match the head of the expectation queue.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!reset && grant != '0) begin
        grant_cnt++;
        check("grant_onehot", int'($onehot(grant)), 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_grant: got grant=%b, required no grant", grant);
        end else begin
          e = exp_q.pop_front();
          check("grant", int'(grant), 1 << e);
          check("active_lane", int'(active_lane), e);
        end
      end
    end
  end

  initial begin
    int clr;
    int base;
    reset    = 1'b1;
    lane_req = '0;
    density  = '0;
    #12;
    reset = 1'b0;
    step();

    // Reset values and idle behaviour with no requests.
    check("rst_grant", int'(grant), 0);
    check("rst_active_lane", int'(active_lane), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_all_red", int'(all_red), 1);
    for (int c = 0; c < 20; c++) begin
      step();
      check("idle_grant", int'(grant), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_all_red", int'(all_red), 1);
    end

    // Single lane service with clearance timing.
    exp_q.push_back(0);
    lane_req = 4'b0001;
    base = grant_cnt;
    wait_grants(base + 1);
    lane_req = '0;
    check("go_all_red_low", int'(all_red), 0);
    clr = 0;
    while (!all_red && clr < 100) begin
      step();
      clr++;
    end
    clr = 0;
    while (all_red && busy && clr < 100) begin
      step();
      clr++;
    end
    check("clearance_cycles", clr, 10);
    check("post_clear_busy", int'(busy), 0);
    check("post_clear_all_red", int'(all_red), 1);

    // Density wins: lane3 (3) over lane1 (1).
    density  = {2'd3, 2'd0, 2'd1, 2'd0};
    exp_q.push_back(3);
    lane_req = 4'b1010;
    base = grant_cnt;
    wait_grants(base + 1);
    lane_req = '0;
    wait_idle();

    // Equal densities from reset: round-robin 0,1,2,3.
    do_reset();
    density = {4{2'd2}};
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    lane_req = 4'b1111;
    base = grant_cnt;
    wait_grants(base + 4);
    lane_req = '0;
    wait_idle();

    // Tie between lanes 1 and 2 after lane 3 was last served.
    for (int i = 1; i < 3; i++) exp_q.push_back(i);
    lane_req = 4'b0110;
    base = grant_cnt;
    wait_grants(base + 2);
    lane_req = '0;
    wait_idle();

    // Low-density lane0 against dense lane1.
    do_reset();
    density = {2'd0, 2'd0, 2'd3, 2'd0};
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(1);
`ifdef SCHED_STARVE_GUARD_EN
    exp_q.push_back(0);
`else
    exp_q.push_back(1);
`endif
    lane_req = 4'b0011;
    base = grant_cnt;
    wait_grants(base + 4);
    lane_req = '0;
    wait_idle();

    // Reset asserted while waiting for red to return.
    do_reset();
    density = '0;
    exp_q.push_back(2);
    lane_req = 4'b0100;
    base = grant_cnt;
    wait_grants(base + 1);
    lane_req = '0;
    step();
    step();
    check("pre_reset_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_grant", int'(grant), 0);
    check("mid_rst_active_lane", int'(active_lane), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_all_red", int'(all_red), 1);
    step();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      check("post_rst_busy", int'(busy), 0);
    end
    exp_q.push_back(3);
    lane_req = 4'b1000;
    base = grant_cnt;
    wait_grants(base + 1);
    lane_req = '0;
    wait_idle();

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
